// File: rtl/led_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table and segment bit positions.
// Latency: n/a (constants and a pure lookup function).
// Backpressure: n/a.
package led_pkg;

  // Segment bit positions inside the 8-bit active-high segment word.
  localparam int SEG_A_BIT  = 7;
  localparam int SEG_B_BIT  = 6;
  localparam int SEG_C_BIT  = 5;
  localparam int SEG_D_BIT  = 4;
  localparam int SEG_E_BIT  = 3;
  localparam int SEG_F_BIT  = 2;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_DP_BIT = 0;

  // All segments dark, active-high sense.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Only the decimal point survives when a digit is blanked.
  localparam logic [7:0] SEG_DP_MASK = 8'h01;

  // Hex glyphs, bit7..bit1 = a..g, bit0 (dp) always clear here.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2,   // 0 1 2 3
    8'h66, 8'hB6, 8'hBE, 8'hE0,   // 4 5 6 7
    8'hFE, 8'hF6, 8'hEE, 8'h3E,   // 8 9 A b
    8'h9C, 8'h7A, 8'h9E, 8'h8E    // C d E F
  };

  function automatic logic [7:0] seg_lookup(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Nibble plus decimal point to active-high 7-segment word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//   nib_i  : hex digit to display
//   dp_i   : decimal point request
//   segs_o : bit7..bit1 = a..g, bit0 = dp, active-high
module hex7_decode
  import led_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] segs_o
);

  always_comb begin
    segs_o             = seg_lookup(nib_i);
    segs_o[SEG_DP_BIT] = segs_o[SEG_DP_BIT] | dp_i;
  end

endmodule

// File: rtl/led_scan.sv
// Time-multiplexed 7-segment scanner: shadows a packed hex value and lights one digit per slot.
// Latency: outputs registered, lag scan state by one cycle; load visible at the next output edge.
// Backpressure: none; load is a strobe and is always accepted, even coincident with a slot wrap.
//   clk, rst_n        : clock and synchronous active-low reset
//   load, value,
//   dp_in, blank_lz   : shadow register write port
//   segs, an          : registered pin drivers (polarity set by parameters)
//   frame_done        : one-cycle pulse when the scan wraps back to digit 0
module led_scan
  import led_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [7:0]            segs,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [7:0]        SEGS_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : SEG_OFF;
  localparam logic [DIGITS-1:0] AN_IDLE   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Scan state
  logic [DW-1:0]       div_q,   div_d;
  logic [IW-1:0]       idx_q,   idx_d;

  // Shadow of the display register
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dp_q,    dp_d;
  logic                blz_q,   blz_d;

  // Output registers
  logic [7:0]          segs_q,  segs_d;
  logic [DIGITS-1:0]   an_q,    an_d;
  logic                fd_q,    fd_d;

  logic                tick;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic [7:0]          dec_segs;
  logic [7:0]          lit_segs;
  logic [DIGITS-1:0]   lz_mask;
  logic [DIGITS-1:0]   an_onehot;
  logic                blank_cur;

  hex7_decode u_dec (
    .nib_i  (cur_nib),
    .dp_i   (cur_dp),
    .segs_o (dec_segs)
  );

  // Scan counter and shadow next-state
  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? '0 : div_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    fd_d    = tick && (idx_q == IDX_LAST);

    // A load landing on a wrap edge still updates the shadow; the two are independent.
    value_d = load ? value    : value_q;
    dp_d    = load ? dp_in    : dp_q;
    blz_d   = load ? blank_lz : blz_q;
  end

  // lz_mask[i] is set when digit i and every digit to its left hold zero.
  always_comb begin
    lz_mask = '0;
    for (int i = 0; i < DIGITS; i++) begin
      lz_mask[i] = ((value_q >> (4 * i)) == '0);
    end
  end

  // Digit selection, blanking and polarity for the next output register value
  always_comb begin
    cur_nib   = value_q[idx_q * 4 +: 4];
    cur_dp    = dp_q[idx_q];
    blank_cur = blz_q && (idx_q != '0) && lz_mask[idx_q];
    lit_segs  = blank_cur ? (dec_segs & SEG_DP_MASK) : dec_segs;

    an_onehot        = '0;
    an_onehot[idx_q] = 1'b1;

    // div==0 is the dead cycle that separates adjacent digits to stop ghosting.
    segs_d = SEGS_IDLE;
    an_d   = AN_IDLE;
    if (div_q != '0) begin
      segs_d = (SEG_ACTIVE_LOW != 0) ? ~lit_segs  : lit_segs;
      an_d   = (AN_ACTIVE_LOW  != 0) ? ~an_onehot : an_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      idx_q   <= '0;
      value_q <= '0;
      dp_q    <= '0;
      blz_q   <= 1'b0;
      segs_q  <= SEGS_IDLE;
      an_q    <= AN_IDLE;
      fd_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      dp_q    <= dp_d;
      blz_q   <= blz_d;
      segs_q  <= segs_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign segs       = segs_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule
